alu_pipe: RTL

//   Parametrised, two-stage pipelined ALU: successor of the 20-bit four-op ALU.

---
 rtl/alu_pkg.sv | 23 ++
 rtl/alu_core.sv | 78 +++++++
 rtl/alu_pipe.sv | 86 ++++++++
 3 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | alu_pkg : opcode encodings and status-flag bit positions for the ALU        |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
package alu_pkg;

  localparam logic [2:0] ALU_OP_AND  = 3'd0;
  localparam logic [2:0] ALU_OP_ADD  = 3'd1;
  localparam logic [2:0] ALU_OP_OR   = 3'd2;
  localparam logic [2:0] ALU_OP_XOR  = 3'd3;
  localparam logic [2:0] ALU_OP_SUB  = 3'd4;
  localparam logic [2:0] ALU_OP_SHL  = 3'd5;
  localparam logic [2:0] ALU_OP_SHR  = 3'd6;
  localparam logic [2:0] ALU_OP_PASS = 3'd7;

  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 2;
  localparam int FLAG_N = 3;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_core.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | alu_core : combinational 8-op ALU, {a,b,op} -> {res,flags}                  |
// | Optional macro ALU_SAT_EN: signed saturation on ADD/SUB overflow.  Rev 1.0  |
// +-----------------------------------------------------------------------------+
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 20
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] res,
  output logic [3:0]       flags
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW:0] WIDTH_V = (SHW+1)'(WIDTH);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [SHW-1:0]   amt;
  logic             shift_oor;
  logic [WIDTH-1:0] raw_res;
  logic             carry;
  logic             ovf;

  assign sum       = {1'b0, a} + {1'b0, b};
  assign diff      = {1'b0, a} - {1'b0, b};
  assign amt       = b[SHW-1:0];
  // Only reachable when WIDTH is not a power of two.
  assign shift_oor = ({1'b0, amt} >= WIDTH_V);

  always_comb begin
    raw_res = '0;
    carry   = 1'b0;
    ovf     = 1'b0;
    case (op)
      ALU_OP_AND: raw_res = a & b;
      ALU_OP_OR:  raw_res = a | b;
      ALU_OP_XOR: raw_res = a ^ b;
      ALU_OP_ADD: begin
        raw_res = sum[WIDTH-1:0];
        carry   = sum[WIDTH];
        ovf     = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_OP_SUB: begin
        raw_res = diff[WIDTH-1:0];
        carry   = diff[WIDTH];
        ovf     = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_OP_SHL: raw_res = shift_oor ? '0 : (a << amt);
      ALU_OP_SHR: raw_res = shift_oor ? '0 : (a >> amt);
      default:    raw_res = b;
    endcase
  end

`ifdef ALU_SAT_EN
  logic [WIDTH-1:0] sat_val;

  // Overflow direction always follows the sign of A for both ADD and SUB.
  assign sat_val = a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  assign res     = ovf ? sat_val : raw_res;
`else
  assign res = raw_res;
`endif

  always_comb begin
    flags         = '0;
    flags[FLAG_Z] = (res == '0);
    flags[FLAG_C] = carry;
    flags[FLAG_V] = ovf;
    flags[FLAG_N] = res[WIDTH-1];
  end

endmodule : alu_core
`default_nettype wire

// File: rtl/alu_pipe.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | alu_pipe : two-stage pipelined ALU with valid/ready on both sides           |
// | Optional macro ALU_SAT_EN (handled in alu_core).  Rev 1.0                   |
// +-----------------------------------------------------------------------------+
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res,
  output logic [3:0]       out_flags
);

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [2:0]       s1_op;
  logic             s2_valid;
  logic [WIDTH-1:0] s2_res;
  logic [3:0]       s2_flags;
  logic             s1_load;
  logic             s2_load;
  logic [WIDTH-1:0] core_res;
  logic [3:0]       core_flags;

  assign s2_load  = !s2_valid || out_ready;
  assign s1_load  = !s1_valid || s2_load;
  assign in_ready = s1_load;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= '0;
    end else if (s1_load) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_a  <= in_a;
        s1_b  <= in_b;
        s1_op <= in_op;
      end
    end
  end

  alu_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .a     (s1_a),
    .b     (s1_b),
    .op    (s1_op),
    .res   (core_res),
    .flags (core_flags)
  );

  // Result registers only update on a real transfer so a stalled output stays put.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_valid <= 1'b0;
      s2_res   <= '0;
      s2_flags <= '0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_res   <= core_res;
        s2_flags <= core_flags;
      end
    end
  end

  assign out_valid = s2_valid;
  assign out_res   = s2_res;
  assign out_flags = s2_flags;

endmodule : alu_pipe
`default_nettype wire
